// File: rtl/updown_pkg.sv
// Shared constants and types for the up/down button controller and its downstream counter.
package updown_pkg;

    localparam int BITS              = 4;
    localparam int DB_CYCLES_DEF     = 8;
    localparam int REPEAT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    typedef enum logic {
        OWN_DOWN = 1'b0,
        OWN_UP   = 1'b1
    } owner_t;

endpackage

// File: rtl/updown_ctrl_btn_debounce.sv
// Per-button front end: 2-flop synchronizer plus a stable-sample counter whose counting
// window is opened and closed by the controller FSM through en.
module btn_debounce
    import updown_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic en,
    output logic sync,
    output logic hit
);

    logic       sync_p0;
    logic       sync_p1;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= 8'd0;
        end else begin
            sync_p0 <= btn;
            // stage boundary: sync_p1 is the first sample safe to use in the clk domain
            sync_p1 <= sync_p0;
            cnt     <= en ? cnt + 8'd1 : 8'd0;
        end
    end

    assign sync = sync_p1;
    // Fires on the sample that completes DB_CYCLES counted samples.
    assign hit  = en && (cnt == 8'(DB_CYCLES - 1));

endmodule

// File: rtl/updown_ctrl.sv
// Up/down button controller: debounces two raw pushbuttons and drives sel/step for a
// downstream up/down counter. Define UPDOWN_AUTOREPEAT_EN to add held-button auto-repeat.
module updown_ctrl
    import updown_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic sel,
    output logic step,
    output logic active
);

    if (DB_CYCLES < 2 || DB_CYCLES > 255 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_cfg
        $error("updown_ctrl: DB_CYCLES or REPEAT_CYCLES out of range");
    end

    state_t state, state_nx;
    owner_t owner, owner_nx;
    logic   sel_nx;
    logic   step_nx;

    logic up_sync, dn_sync;
    logic up_hit, dn_hit;
    logic up_en, dn_en;
    logic own_sync, oth_sync, own_hit;
    logic cnt_en;
    logic rpt_fire;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .en    (up_en),
        .sync  (up_sync),
        .hit   (up_hit)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .en    (dn_en),
        .sync  (dn_sync),
        .hit   (dn_hit)
    );

    assign own_sync = (owner == OWN_UP) ? up_sync : dn_sync;
    assign oth_sync = (owner == OWN_UP) ? dn_sync : up_sync;
    assign own_hit  = (owner == OWN_UP) ? up_hit  : dn_hit;

    // Only the owner's counter runs: high samples while arming, low samples while releasing.
    // The first low sample in PRESSED already counts toward the release window.
    assign cnt_en = ((state == ST_ARMING) && own_sync && !oth_sync) ||
                    ((state == ST_PRESSED || state == ST_RELEASING) && !own_sync);
    assign up_en  = cnt_en && (owner == OWN_UP);
    assign dn_en  = cnt_en && (owner == OWN_DOWN);

`ifdef UPDOWN_AUTOREPEAT_EN
    logic [15:0] rpt_cnt, rpt_cnt_nx;

    always_comb begin
        rpt_cnt_nx = 16'd0;
        rpt_fire   = 1'b0;
        if (state == ST_PRESSED && own_sync) begin
            if (rpt_cnt == 16'(REPEAT_CYCLES - 1)) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_cnt_nx = rpt_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt <= 16'd0;
        end else begin
            rpt_cnt <= rpt_cnt_nx;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        sel_nx   = sel;
        step_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Both buttons high is ambiguous, so only a lone press starts arming.
                if (up_sync ^ dn_sync) begin
                    state_nx = ST_ARMING;
                    owner_nx = up_sync ? OWN_UP : OWN_DOWN;
                end
            end
            ST_ARMING: begin
                if (!own_sync || oth_sync) begin
                    state_nx = ST_IDLE;
                end else if (own_hit) begin
                    state_nx = ST_PRESSED;
                    step_nx  = 1'b1;
                    sel_nx   = (owner == OWN_UP);
                end
            end
            ST_PRESSED: begin
                if (!own_sync) begin
                    state_nx = ST_RELEASING;
                end else if (rpt_fire) begin
                    step_nx = 1'b1;
                end
            end
            ST_RELEASING: begin
                if (own_sync) begin
                    state_nx = ST_PRESSED;
                end else if (own_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            owner <= OWN_UP;
            sel   <= 1'b1;
            step  <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            sel   <= sel_nx;
            step  <= step_nx;
        end
    end

    assign active = (state == ST_PRESSED) || (state == ST_RELEASING);

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl (DB_CYCLES=8, REPEAT_CYCLES=16); expectations follow
// UPDOWN_AUTOREPEAT_EN when it is defined for the build.
module tb_updown_ctrl;
    import updown_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic sel, step, active;

    int checks = 0;
    int failures = 0;
    int step_at[$];
    logic consec;
    logic [BITS-1:0] ctr = '0;

    updown_ctrl #(.DB_CYCLES(8), .REPEAT_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .sel      (sel),
        .step     (step),
        .active   (active)
    );

    always #5 clk = ~clk;

    // Run n cycles, logging the cycle index of every step and feeding a 4-bit up/down counter.
    // Cycle 0 is the first rising edge after the call; sampling is 1ns after each edge.
    task automatic run(input int n);
        step_at.delete();
        consec = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (step) begin
                if (step_at.size() > 0 && step_at[$] == c - 1) consec = 1'b1;
                step_at.push_back(c);
                ctr = sel ? ctr + BITS'(1) : ctr - BITS'(1);
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        ctr = '0;
    endtask

    function automatic int first_step();
        return (step_at.size() > 0) ? step_at[0] : -1;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL reset_sel: got %b expected 1", sel); end
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step: got %b expected 0", step); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b expected 0", active); end
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (active !== 1'b0 || step !== 1'b0) begin failures++; $display("FAIL reset_hold: got active=%b step=%b expected 0 0", active, step); end
        reset = 1'b1;
    endtask

    task automatic test_single_up();
        btn_up = 1'b1;
        run(20);
        checks++; if (step_at.size() != 1) begin failures++; $display("FAIL up_step_count: got %0d expected 1", step_at.size()); end
        checks++; if (first_step() != 10) begin failures++; $display("FAIL up_latency: got %0d expected 10", first_step()); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL up_sel: got %b expected 1", sel); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL up_active: got %b expected 1", active); end
        btn_up = 1'b0;
        run(20);
        checks++; if (step_at.size() != 0) begin failures++; $display("FAIL up_release_steps: got %0d expected 0", step_at.size()); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL up_release_active: got %b expected 0", active); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL up_release_sel: got %b expected 1", sel); end
    endtask

    task automatic test_glitch_down();
        btn_down = 1'b1;
        run(5);
        checks++; if (step_at.size() != 0) begin failures++; $display("FAIL glitch_steps_hi: got %0d expected 0", step_at.size()); end
        btn_down = 1'b0;
        run(15);
        checks++; if (step_at.size() != 0) begin failures++; $display("FAIL glitch_steps_lo: got %0d expected 0", step_at.size()); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL glitch_sel: got %b expected 1", sel); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL glitch_active: got %b expected 0", active); end
        // A full-latency press afterwards shows the FSM went back to IDLE with a cleared count.
        btn_up = 1'b1;
        run(14);
        checks++; if (first_step() != 10) begin failures++; $display("FAIL glitch_idle_latency: got %0d expected 10", first_step()); end
        btn_up = 1'b0;
        run(15);
    endtask

    task automatic test_both();
        apply_reset();
        btn_up = 1'b1;
        btn_down = 1'b1;
        run(30);
        checks++; if (step_at.size() != 0) begin failures++; $display("FAIL both_steps: got %0d expected 0", step_at.size()); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL both_sel: got %b expected 1", sel); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL both_active: got %b expected 0", active); end
        btn_down = 1'b0;
        run(14);
        checks++; if (first_step() != 10) begin failures++; $display("FAIL both_then_up_latency: got %0d expected 10", first_step()); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL both_then_up_active: got %b expected 1", active); end
        btn_up = 1'b0;
        run(15);
        // Other button rising during arming aborts; arming restarts from 0 once it drops.
        btn_up = 1'b1;
        run(4);
        btn_down = 1'b1;
        run(10);
        checks++; if (step_at.size() != 0 || active !== 1'b0) begin failures++; $display("FAIL arm_abort: got steps=%0d active=%b expected 0 0", step_at.size(), active); end
        btn_down = 1'b0;
        run(14);
        checks++; if (first_step() != 10) begin failures++; $display("FAIL arm_restart_latency: got %0d expected 10", first_step()); end
        btn_up = 1'b0;
        run(15);
    endtask

    task automatic test_down_reset();
        apply_reset();
        btn_down = 1'b1;
        run(3);
        #2 reset = 1'b0;
        #1;
        checks++; if (sel !== 1'b1 || step !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL rst_mid_debounce: got sel=%b step=%b active=%b expected 1 0 0", sel, step, active); end
        @(posedge clk);
        #1 reset = 1'b1;
        run(14);
        checks++; if (step_at.size() != 1 || first_step() != 10) begin failures++; $display("FAIL rst_debounce_redo: got steps=%0d first=%0d expected 1 10", step_at.size(), first_step()); end
        checks++; if (sel !== 1'b0 || active !== 1'b1) begin failures++; $display("FAIL down_accept: got sel=%b active=%b expected 0 1", sel, active); end
        #2 reset = 1'b0;
        #1;
        checks++; if (sel !== 1'b1 || step !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL rst_mid_press: got sel=%b step=%b active=%b expected 1 0 0", sel, step, active); end
        @(posedge clk);
        #1 reset = 1'b1;
        run(14);
        checks++; if (step_at.size() != 1 || first_step() != 10) begin failures++; $display("FAIL rst_press_redo: got steps=%0d first=%0d expected 1 10", step_at.size(), first_step()); end
        btn_down = 1'b0;
        run(15);
        checks++; if (sel !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL down_release: got sel=%b active=%b expected 0 0", sel, active); end
    endtask

    task automatic test_counter();
        logic [BITS-1:0] exp_ctr [3];
        exp_ctr = '{4'd15, 4'd14, 4'd13};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            btn_down = 1'b1;
            run(14);
            btn_down = 1'b0;
            run(14);
            checks++; if (ctr !== exp_ctr[i]) begin failures++; $display("FAIL counter_down%0d: got %0d expected %0d", i, ctr, exp_ctr[i]); end
        end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL counter_sel_down: got %b expected 0", sel); end
        btn_up = 1'b1;
        run(14);
        btn_up = 1'b0;
        run(14);
        checks++; if (ctr !== 4'd14 || sel !== 1'b1) begin failures++; $display("FAIL counter_up: got ctr=%0d sel=%b expected 14 1", ctr, sel); end
    endtask

    task automatic test_autorepeat();
        int exp_at [4];
        int exp_n;
        int got;
`ifdef UPDOWN_AUTOREPEAT_EN
        exp_at = '{10, 26, 42, 58};
        exp_n = 4;
`else
        exp_at = '{10, -1, -1, -1};
        exp_n = 1;
`endif
        apply_reset();
        btn_up = 1'b1;
        run(60);
        checks++; if (step_at.size() != exp_n) begin failures++; $display("FAIL repeat_count: got %0d expected %0d", step_at.size(), exp_n); end
        for (int k = 0; k < 4; k++) begin
            got = (k < step_at.size()) ? step_at[k] : -1;
            checks++; if (got != exp_at[k]) begin failures++; $display("FAIL repeat_at%0d: got %0d expected %0d", k, got, exp_at[k]); end
        end
        checks++; if (consec !== 1'b0) begin failures++; $display("FAIL repeat_consecutive: got %b expected 0", consec); end
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL repeat_sel: got %b expected 1", sel); end
        btn_up = 1'b0;
        run(20);
        checks++; if (step_at.size() != 0 || active !== 1'b0) begin failures++; $display("FAIL repeat_release: got steps=%0d active=%b expected 0 0", step_at.size(), active); end
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_glitch_down();
        test_both();
        test_down_reset();
        test_counter();
        test_autorepeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
